wb_interconnect_tag_reg_1xn: RTL and testbench

Registered single-initiator, N-target tagged Wishbone interconnect. It sits between one tagged Wishbone initiator and N address-mapped target ports, and is the pipelined successor to the combinational 1xN tagged interconnect. It breaks the combinational path with a request/response register stage and latches the decoded target for the life of each transfer. It also returns a one-cycle error for unmapped addresses and aborts stalled transfers with a programmable timeout, recording the failing address.

---
 rtl/wb_interconnect_tag_reg_1xn.sv | 231 +++++++++++++++++++++++
 tb/tb_wb_interconnect_tag_reg_1xn.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_interconnect_tag_reg_1xn.sv
// Registered 1xN tagged Wishbone interconnect: latches the decoded target per transfer,
// answers unmapped addresses with an error and aborts stalled targets after TIMEOUT cycles.
module wb_interconnect_tag_reg_1xn #(
  parameter int unsigned ADR_WIDTH = 32,
  parameter int unsigned DAT_WIDTH = 32,
  parameter int unsigned TGA_WIDTH = 4,
  parameter int unsigned TGD_WIDTH = 4,
  parameter int unsigned TGC_WIDTH = 4,
  parameter int unsigned N_TARGETS = 1,
  parameter logic [N_TARGETS*ADR_WIDTH-1:0] T_ADR_MASK = {8'hFF, 24'h0},
  parameter logic [N_TARGETS*ADR_WIDTH-1:0] T_ADR = 32'h2800_0000,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [ADR_WIDTH-1:0]           t_adr,
  input  logic [DAT_WIDTH-1:0]           t_dat_w,
  input  logic [DAT_WIDTH/8-1:0]         t_sel,
  input  logic                           t_we,
  input  logic                           t_cyc,
  input  logic                           t_stb,
  input  logic [TGA_WIDTH-1:0]           t_tga,
  input  logic [TGC_WIDTH-1:0]           t_tgc,
  input  logic [TGD_WIDTH-1:0]           t_tgd_w,
  output logic [DAT_WIDTH-1:0]           t_dat_r,
  output logic [TGD_WIDTH-1:0]           t_tgd_r,
  output logic                           t_ack,
  output logic                           t_err,
  output logic [N_TARGETS*ADR_WIDTH-1:0] i_adr,
  output logic [N_TARGETS*DAT_WIDTH-1:0] i_dat_w,
  output logic [N_TARGETS*DAT_WIDTH/8-1:0] i_sel,
  output logic [N_TARGETS-1:0]           i_we,
  output logic [N_TARGETS-1:0]           i_cyc,
  output logic [N_TARGETS-1:0]           i_stb,
  output logic [N_TARGETS*TGA_WIDTH-1:0] i_tga,
  output logic [N_TARGETS*TGC_WIDTH-1:0] i_tgc,
  output logic [N_TARGETS*TGD_WIDTH-1:0] i_tgd_w,
  input  logic [N_TARGETS*DAT_WIDTH-1:0] i_dat_r,
  input  logic [N_TARGETS*TGD_WIDTH-1:0] i_tgd_r,
  input  logic [N_TARGETS-1:0]           i_ack,
  input  logic [N_TARGETS-1:0]           i_err,
  output logic                           err_pulse,
  output logic [ADR_WIDTH-1:0]           err_adr
);

  localparam int unsigned SEL_WIDTH = DAT_WIDTH / 8;
  localparam int unsigned IDX_WIDTH = (N_TARGETS > 1) ? $clog2(N_TARGETS) : 1;
  localparam int unsigned CNT_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, RESP, DERR} state_t;

  state_t                 state_q, state_d;
  logic [IDX_WIDTH-1:0]   tgt_q, tgt_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ADR_WIDTH-1:0]   adr_q, adr_d;
  logic [DAT_WIDTH-1:0]   dat_q, dat_d;
  logic [SEL_WIDTH-1:0]   bsel_q, bsel_d;
  logic                   we_q, we_d;
  logic [TGA_WIDTH-1:0]   tga_q, tga_d;
  logic [TGC_WIDTH-1:0]   tgc_q, tgc_d;
  logic [TGD_WIDTH-1:0]   tgdw_q, tgdw_d;
  logic [N_TARGETS-1:0]   act_q, act_d;
  logic [DAT_WIDTH-1:0]   dat_r_q, dat_r_d;
  logic [TGD_WIDTH-1:0]   tgd_r_q, tgd_r_d;
  logic                   ack_q, ack_d, err_q, err_d, pulse_q, pulse_d;
  logic [ADR_WIDTH-1:0]   eadr_q, eadr_d;

  logic                   hit;
  logic [IDX_WIDTH-1:0]   hit_idx;
  logic [DAT_WIDTH-1:0]   sel_dat;
  logic [TGD_WIDTH-1:0]   sel_tgd;
  logic                   sel_ack, sel_err;

  // Address decode; iterating downward lets the lowest matching slot win.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = N_TARGETS - 1; k >= 0; k--) begin
      if ((t_adr & T_ADR_MASK[k*ADR_WIDTH +: ADR_WIDTH]) == T_ADR[k*ADR_WIDTH +: ADR_WIDTH]) begin
        hit     = 1'b1;
        hit_idx = IDX_WIDTH'(k);
      end
    end
  end

  // Response mux for the latched target; other ports are ignored.
  always_comb begin
    sel_dat = '0;
    sel_tgd = '0;
    sel_ack = 1'b0;
    sel_err = 1'b0;
    for (int k = 0; k < N_TARGETS; k++) begin
      if (tgt_q == IDX_WIDTH'(k)) begin
        sel_dat = i_dat_r[k*DAT_WIDTH +: DAT_WIDTH];
        sel_tgd = i_tgd_r[k*TGD_WIDTH +: TGD_WIDTH];
        sel_ack = i_ack[k];
        sel_err = i_err[k];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    bsel_d  = bsel_q;
    we_d    = we_q;
    tga_d   = tga_q;
    tgc_d   = tgc_q;
    tgdw_d  = tgdw_q;
    act_d   = act_q;
    dat_r_d = dat_r_q;
    tgd_r_d = tgd_r_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    pulse_d = 1'b0;
    eadr_d  = eadr_q;
    unique case (state_q)
      IDLE: begin
        if (t_cyc && t_stb) begin
          adr_d  = t_adr;
          dat_d  = t_dat_w;
          bsel_d = t_sel;
          we_d   = t_we;
          tga_d  = t_tga;
          tgc_d  = t_tgc;
          tgdw_d = t_tgd_w;
          if (hit) begin
            tgt_d   = hit_idx;
            cnt_d   = '0;
            state_d = ACTIVE;
            for (int k = 0; k < N_TARGETS; k++) act_d[k] = (hit_idx == IDX_WIDTH'(k));
          end else begin
            state_d = DERR;
            err_d   = 1'b1;
            dat_r_d = '0;
            tgd_r_d = '0;
            pulse_d = 1'b1;
            eadr_d  = t_adr;
          end
        end
      end
      ACTIVE: begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (!t_cyc) begin
          act_d   = '0;
          state_d = IDLE;
        end else if (sel_err || sel_ack) begin
          // Error outranks ack when a target raises both.
          act_d   = '0;
          dat_r_d = sel_dat;
          tgd_r_d = sel_tgd;
          err_d   = sel_err;
          ack_d   = !sel_err;
          state_d = RESP;
        end else if (TIMEOUT != 0 && cnt_q == CNT_WIDTH'(TIMEOUT - 1)) begin
          act_d   = '0;
          dat_r_d = '0;
          tgd_r_d = '0;
          err_d   = 1'b1;
          pulse_d = 1'b1;
          eadr_d  = adr_q;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      DERR:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      cnt_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      bsel_q  <= '0;
      we_q    <= 1'b0;
      tga_q   <= '0;
      tgc_q   <= '0;
      tgdw_q  <= '0;
      act_q   <= '0;
      dat_r_q <= '0;
      tgd_r_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      pulse_q <= 1'b0;
      eadr_q  <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      bsel_q  <= bsel_d;
      we_q    <= we_d;
      tga_q   <= tga_d;
      tgc_q   <= tgc_d;
      tgdw_q  <= tgdw_d;
      act_q   <= act_d;
      dat_r_q <= dat_r_d;
      tgd_r_q <= tgd_r_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      pulse_q <= pulse_d;
      eadr_q  <= eadr_d;
    end
  end

  // Shared request registers fan out to every port; only cyc/stb are per-target.
  assign i_adr     = {N_TARGETS{adr_q}};
  assign i_dat_w   = {N_TARGETS{dat_q}};
  assign i_sel     = {N_TARGETS{bsel_q}};
  assign i_we      = {N_TARGETS{we_q}};
  assign i_tga     = {N_TARGETS{tga_q}};
  assign i_tgc     = {N_TARGETS{tgc_q}};
  assign i_tgd_w   = {N_TARGETS{tgdw_q}};
  assign i_cyc     = act_q;
  assign i_stb     = act_q;
  assign t_dat_r   = dat_r_q;
  assign t_tgd_r   = tgd_r_q;
  assign t_ack     = ack_q;
  assign t_err     = err_q;
  assign err_pulse = pulse_q;
  assign err_adr   = eadr_q;

endmodule

// File: tb/tb_wb_interconnect_tag_reg_1xn.sv
// Bench for wb_interconnect_tag_reg_1xn: three targets (slot 2 overlaps slot 0), TIMEOUT=8,
// vector table plus scoreboard of expected responses, and hand sequences for abort and reset.
module tb_wb_interconnect_tag_reg_1xn;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned N  = 3;
  localparam int unsigned TO = 8;

  logic clock, reset;
  logic [AW-1:0] t_adr;
  logic [DW-1:0] t_dat_w;
  logic [3:0] t_sel, t_tga, t_tgc, t_tgd_w;
  logic t_we, t_cyc, t_stb;
  logic [DW-1:0] t_dat_r;
  logic [3:0] t_tgd_r;
  logic t_ack, t_err, err_pulse;
  logic [AW-1:0] err_adr;
  logic [N*AW-1:0] i_adr;
  logic [N*DW-1:0] i_dat_w, i_dat_r;
  logic [N*4-1:0] i_sel, i_tga, i_tgc, i_tgd_w, i_tgd_r;
  logic [N-1:0] i_we, i_cyc, i_stb, i_ack, i_err;

  wb_interconnect_tag_reg_1xn #(
    .ADR_WIDTH(AW), .DAT_WIDTH(DW), .TGA_WIDTH(4), .TGD_WIDTH(4), .TGC_WIDTH(4),
    .N_TARGETS(N),
    .T_ADR_MASK({3{32'hF000_0000}}),
    .T_ADR({32'h1000_0000, 32'h2000_0000, 32'h1000_0000}),
    .TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset(reset),
    .t_adr(t_adr), .t_dat_w(t_dat_w), .t_sel(t_sel), .t_we(t_we), .t_cyc(t_cyc), .t_stb(t_stb),
    .t_tga(t_tga), .t_tgc(t_tgc), .t_tgd_w(t_tgd_w),
    .t_dat_r(t_dat_r), .t_tgd_r(t_tgd_r), .t_ack(t_ack), .t_err(t_err),
    .i_adr(i_adr), .i_dat_w(i_dat_w), .i_sel(i_sel), .i_we(i_we), .i_cyc(i_cyc), .i_stb(i_stb),
    .i_tga(i_tga), .i_tgc(i_tgc), .i_tgd_w(i_tgd_w),
    .i_dat_r(i_dat_r), .i_tgd_r(i_tgd_r), .i_ack(i_ack), .i_err(i_err),
    .err_pulse(err_pulse), .err_adr(err_adr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Target model: each port answers once it has seen stb for tdelay cycles.
  logic [1:0] tmode;   // bit0 ack, bit1 err
  int         tdelay;
  logic [N-1:0] spur;  // ack forced on a port regardless of selection
  logic [7:0] wcnt [N];

  always_ff @(posedge clock or posedge reset) begin
    for (int k = 0; k < N; k++) begin
      if (reset) wcnt[k] <= '0;
      else       wcnt[k] <= (i_cyc[k] && i_stb[k]) ? wcnt[k] + 8'd1 : 8'd0;
    end
  end

  always_comb begin
    i_ack = '0;
    i_err = '0;
    for (int k = 0; k < N; k++) begin
      i_ack[k] = (i_cyc[k] && i_stb[k] && int'(wcnt[k]) >= tdelay && tmode[0]) || spur[k];
      i_err[k] = i_cyc[k] && i_stb[k] && int'(wcnt[k]) >= tdelay && tmode[1];
    end
  end

  assign i_dat_r = {32'h2222_0000, 32'hCAFE_F00D, 32'h1111_0000};
  assign i_tgd_r = {4'h9, 4'h5, 4'h3};

  typedef struct {
    logic [31:0] adr; logic we; logic [31:0] dat; logic [3:0] sel; logic [3:0] tga;
    logic [1:0] mode; int delay; logic [2:0] spur; logic [2:0] port;
    logic ack; logic err; logic [31:0] rdat; logic [3:0] rtgd; int lat; logic pulse;
  } vec_t;

  typedef struct {
    logic ack; logic err; logic [31:0] dat; logic [3:0] tgd; logic pulse; logic [31:0] eadr;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[9];
  int n_cmp = 0;
  int n_bad = 0;
  int resp_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer, called once per cycle at the falling edge.
  task automatic monitor();
    exp_t e;
    if (t_ack || t_err) begin
      resp_cnt++;
      chk("ack_err_exclusive", 128'(t_ack && t_err), 128'(1'b0));
      if (sb.size() == 0) begin
        chk("unexpected_response", 128'(1'b1), 128'(1'b0));
      end else begin
        e = sb.pop_front();
        chk("t_ack", 128'(t_ack), 128'(e.ack));
        chk("t_err", 128'(t_err), 128'(e.err));
        chk("t_dat_r", 128'(t_dat_r), 128'(e.dat));
        chk("t_tgd_r", 128'(t_tgd_r), 128'(e.tgd));
        chk("err_pulse", 128'(err_pulse), 128'(e.pulse));
        if (e.pulse) chk("err_adr", 128'(err_adr), 128'(e.eadr));
      end
    end
  endtask

  task automatic run(input vec_t v);
    int lat;
    logic got;
    @(negedge clock);
    t_adr = v.adr; t_we = v.we; t_dat_w = v.dat; t_sel = v.sel; t_tga = v.tga;
    t_tgc = 4'hC; t_tgd_w = 4'h7;
    tmode = v.mode; tdelay = v.delay; spur = v.spur;
    t_cyc = 1'b1; t_stb = 1'b1;
    sb.push_back('{ack: v.ack, err: v.err, dat: v.rdat, tgd: v.rtgd, pulse: v.pulse, eadr: v.adr});
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clock);
      lat++;
      if (lat == 1) begin
        chk("i_stb_onehot", 128'(i_stb), 128'(v.port));
        chk("i_cyc_onehot", 128'(i_cyc), 128'(v.port));
        chk("i_dat_w_bcast", 128'(i_dat_w), 128'({3{v.dat}}));
        chk("i_sel_bcast", 128'(i_sel), 128'({3{v.sel}}));
        chk("i_we_bcast", 128'(i_we), 128'({3{v.we}}));
        chk("i_tga_bcast", 128'(i_tga), 128'({3{v.tga}}));
      end
      got = t_ack || t_err;
      monitor();
    end
    chk("latency", 128'(lat), 128'(v.lat));
    if (!got) sb.delete();
    t_cyc = 1'b0; t_stb = 1'b0; spur = '0; tmode = '0;
    @(negedge clock);
    monitor();
    chk("idle_cyc_clear", 128'(i_cyc), 128'(3'b000));
    chk("req_adr_hold", 128'(i_adr), 128'({3{v.adr}}));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_t_ack"}, 128'(t_ack), 128'(1'b0));
    chk({tag, "_t_err"}, 128'(t_err), 128'(1'b0));
    chk({tag, "_t_dat_r"}, 128'(t_dat_r), 128'(32'h0));
    chk({tag, "_t_tgd_r"}, 128'(t_tgd_r), 128'(4'h0));
    chk({tag, "_i_cyc"}, 128'(i_cyc), 128'(3'b000));
    chk({tag, "_i_stb"}, 128'(i_stb), 128'(3'b000));
    chk({tag, "_i_adr"}, 128'(i_adr), 128'(96'h0));
    chk({tag, "_i_dat_w"}, 128'(i_dat_w), 128'(96'h0));
    chk({tag, "_err_pulse"}, 128'(err_pulse), 128'(1'b0));
    chk({tag, "_err_adr"}, 128'(err_adr), 128'(32'h0));
  endtask

  initial begin
    int base;
    reset = 1'b1;
    t_adr = '0; t_dat_w = '0; t_sel = '0; t_we = 1'b0; t_cyc = 1'b0; t_stb = 1'b0;
    t_tga = '0; t_tgc = '0; t_tgd_w = '0;
    tmode = '0; tdelay = 0; spur = '0;

    vecs[0] = '{adr: 32'h2000_0010, we: 1'b0, dat: 32'h0, sel: 4'hF, tga: 4'h1, mode: 2'b01, delay: 0,
                spur: 3'b000, port: 3'b010, ack: 1'b1, err: 1'b0, rdat: 32'hCAFE_F00D, rtgd: 4'h5, lat: 2, pulse: 1'b0};
    vecs[1] = '{adr: 32'h1000_0004, we: 1'b1, dat: 32'h1234_5678, sel: 4'hF, tga: 4'h2, mode: 2'b01, delay: 3,
                spur: 3'b010, port: 3'b001, ack: 1'b1, err: 1'b0, rdat: 32'h1111_0000, rtgd: 4'h3, lat: 5, pulse: 1'b0};
    vecs[2] = '{adr: 32'h3000_0000, we: 1'b0, dat: 32'hA5A5_A5A5, sel: 4'h3, tga: 4'h3, mode: 2'b01, delay: 0,
                spur: 3'b000, port: 3'b000, ack: 1'b0, err: 1'b1, rdat: 32'h0, rtgd: 4'h0, lat: 1, pulse: 1'b1};
    vecs[3] = '{adr: 32'h1000_0100, we: 1'b0, dat: 32'h0, sel: 4'hF, tga: 4'h4, mode: 2'b00, delay: 0,
                spur: 3'b000, port: 3'b001, ack: 1'b0, err: 1'b1, rdat: 32'h0, rtgd: 4'h0, lat: 9, pulse: 1'b1};
    vecs[4] = '{adr: 32'h2000_0020, we: 1'b0, dat: 32'h0, sel: 4'hF, tga: 4'h5, mode: 2'b11, delay: 1,
                spur: 3'b000, port: 3'b010, ack: 1'b0, err: 1'b1, rdat: 32'hCAFE_F00D, rtgd: 4'h5, lat: 3, pulse: 1'b0};
    vecs[5] = '{adr: 32'h2000_0040, we: 1'b1, dat: 32'hDEAD_BEEF, sel: 4'h8, tga: 4'h6, mode: 2'b10, delay: 0,
                spur: 3'b000, port: 3'b010, ack: 1'b0, err: 1'b1, rdat: 32'hCAFE_F00D, rtgd: 4'h5, lat: 2, pulse: 1'b0};
    vecs[6] = '{adr: 32'h1000_0008, we: 1'b0, dat: 32'h0, sel: 4'hF, tga: 4'h7, mode: 2'b01, delay: 7,
                spur: 3'b000, port: 3'b001, ack: 1'b1, err: 1'b0, rdat: 32'h1111_0000, rtgd: 4'h3, lat: 9, pulse: 1'b0};
    vecs[7] = '{adr: 32'h2000_00FC, we: 1'b0, dat: 32'h0, sel: 4'hF, tga: 4'h8, mode: 2'b01, delay: 6,
                spur: 3'b000, port: 3'b010, ack: 1'b1, err: 1'b0, rdat: 32'hCAFE_F00D, rtgd: 4'h5, lat: 8, pulse: 1'b0};
    vecs[8] = '{adr: 32'hF000_0000, we: 1'b1, dat: 32'h5555_AAAA, sel: 4'h1, tga: 4'h9, mode: 2'b01, delay: 0,
                spur: 3'b000, port: 3'b000, ack: 1'b0, err: 1'b1, rdat: 32'h0, rtgd: 4'h0, lat: 1, pulse: 1'b1};

    repeat (2) @(negedge clock);
    chk_reset_vals("reset");
    reset = 1'b0;

    foreach (vecs[i]) run(vecs[i]);

    // Initiator abort two cycles into ACTIVE: cyc/stb drop, no response ever.
    @(negedge clock);
    t_adr = 32'h2000_0000; tmode = 2'b00; t_cyc = 1'b1; t_stb = 1'b1;
    @(negedge clock);
    chk("abort_stb_before", 128'(i_stb), 128'(3'b010));
    @(negedge clock);
    t_cyc = 1'b0; t_stb = 1'b0;
    @(negedge clock);
    chk("abort_cyc_clear", 128'(i_cyc), 128'(3'b000));
    chk("abort_stb_clear", 128'(i_stb), 128'(3'b000));
    base = resp_cnt;
    repeat (12) begin
      @(negedge clock);
      monitor();
    end
    chk("abort_no_response", 128'(resp_cnt - base), 128'(0));

    run(vecs[3]);

    // Reset mid-ACTIVE clears everything at once.
    @(negedge clock);
    t_adr = 32'h1000_0000; tmode = 2'b00; t_cyc = 1'b1; t_stb = 1'b1;
    repeat (3) @(negedge clock);
    chk("pre_reset_cyc", 128'(i_cyc), 128'(3'b001));
    reset = 1'b1;
    #1;
    chk_reset_vals("midreset");
    t_cyc = 1'b0; t_stb = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    base = resp_cnt;
    repeat (3) begin
      @(negedge clock);
      monitor();
    end
    chk("reset_no_response", 128'(resp_cnt - base), 128'(0));

    run(vecs[0]);
    chk("scoreboard_drained", 128'(sb.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
